// File: rtl/alu_pkg.sv
// Shared ALU operation codes and the multiply sequencer state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b001;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'd0,
        MULT_RUN  = 2'd1,
        MULT_FIX  = 2'd2,
        MULT_DONE = 2'd3
    } mult_state_t;

endpackage

// File: rtl/alu_mult_sequencer.sv
// Shift-and-add multiplier that borrows the shared ALU for every partial-product add.
// Define SIGNED_MULT_EN to add the signed_op port and the FIX (sign restore) state.
module alu_mult_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
`ifdef SIGNED_MULT_EN
    input  logic             signed_op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    output mult_state_t      state_dbg
);

    // Handshake: start is a request taken only in MULT_IDLE (no ready signal, no queuing);
    // done is a one-cycle valid pulse for hi/lo, which then hold until the next accepted start.

    mult_state_t      state, state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             last_iter;
    logic             carry;
    logic             fix_needed;
    logic [WIDTH-1:0] a_load, b_load;
    logic             neg_load;

`ifdef SIGNED_MULT_EN
    logic             sgn_q, neg_q;
    logic [2*WIDTH-1:0] prod_neg;

    // Signed operands are run as magnitudes; the sign is restored in FIX.
    assign a_load   = (signed_op && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    assign b_load   = (signed_op && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
    assign neg_load = signed_op && (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
    assign prod_neg = -{hi_q, lo_q};
    assign fix_needed = sgn_q;
`else
    assign a_load     = multiplicand;
    assign b_load     = multiplier;
    assign neg_load   = 1'b0;
    assign fix_needed = 1'b0;
`endif

    assign last_iter = (count == CNT_W'(WIDTH - 1));
    assign carry     = (alu_result < hi_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= MULT_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        alu_a       = '0;
        alu_b       = '0;
        alu_control = ALU_ADD;
        case (state)
            MULT_IDLE: begin
                if (start) begin
                    state_next = MULT_RUN;
                end
            end
            MULT_RUN: begin
                alu_a = hi_q;
                alu_b = lo_q[0] ? mcand : '0;
                if (last_iter) begin
                    state_next = fix_needed ? MULT_FIX : MULT_DONE;
                end
            end
            MULT_FIX:  state_next = MULT_DONE;
            MULT_DONE: state_next = MULT_IDLE;
            default:   state_next = MULT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            mcand <= '0;
            count <= '0;
`ifdef SIGNED_MULT_EN
            sgn_q <= 1'b0;
            neg_q <= 1'b0;
`endif
        end else begin
            case (state)
                MULT_IDLE: begin
                    if (start) begin
                        mcand <= a_load;
                        hi_q  <= '0;
                        lo_q  <= b_load;
                        count <= '0;
`ifdef SIGNED_MULT_EN
                        sgn_q <= signed_op;
                        neg_q <= neg_load;
`endif
                    end
                end
                MULT_RUN: begin
                    // The ALU carry-out is lost, so it is rebuilt from the wrap-around compare.
                    hi_q  <= {carry, alu_result[WIDTH-1:1]};
                    lo_q  <= {alu_result[0], lo_q[WIDTH-1:1]};
                    count <= count + CNT_W'(1);
                end
`ifdef SIGNED_MULT_EN
                MULT_FIX: begin
                    if (neg_q) begin
                        {hi_q, lo_q} <= prod_neg;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

`ifndef SIGNED_MULT_EN
    logic unused_ok;
    assign unused_ok = neg_load;
`endif

    assign busy      = (state == MULT_RUN) || (state == MULT_FIX);
    assign done      = (state == MULT_DONE);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Bench for alu_mult_sequencer with a behavioural ALU; honours SIGNED_MULT_EN when defined.
module tb_alu_mult_sequencer;
    import alu_pkg::*;

    localparam int WIDTH = 32;
`ifdef SIGNED_MULT_EN
    localparam bit HAS_SIGNED = 1'b1;
`else
    localparam bit HAS_SIGNED = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              signed_op = 1'b0;
    logic [WIDTH-1:0]  multiplicand = '0;
    logic [WIDTH-1:0]  multiplier = '0;
    logic              busy, done;
    logic [WIDTH-1:0]  hi, lo, alu_a, alu_b, alu_result;
    logic [2:0]        alu_control;
    mult_state_t       state_dbg;

    int checks = 0;
    int failures = 0;
    logic [2*WIDTH-1:0] exp_q[$];

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sgn;
        logic [WIDTH-1:0] exp_hi;
        logic [WIDTH-1:0] exp_lo;
    } vec_t;
    vec_t vecs[$];

    // ---------------- clock / reset / ALU ----------------
    always #1 clk = ~clk;

    always_comb begin
        case (alu_control)
            3'b101:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            default: alu_result = '0;
        endcase
    end

    alu_mult_sequencer #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
`ifdef SIGNED_MULT_EN
        .signed_op    (signed_op),
`endif
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_control  (alu_control),
        .alu_result   (alu_result),
        .state_dbg    (state_dbg)
    );

    // ---------------- reference model ----------------
    function automatic logic [2*WIDTH-1:0] ref_product(input logic [WIDTH-1:0] a,
                                                        input logic [WIDTH-1:0] b,
                                                        input logic sgn);
        longint sa, sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic sgn, input logic [2*WIDTH-1:0] exp);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        signed_op    = sgn;
        start        = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
    endtask

    // n counts posedges after the accepting edge; pulse_at injects an ignored start request.
    task automatic wait_done(input int exp_lat, input string name, input int pulse_at);
        int n, bad;
        bit seen;
        logic [2*WIDTH-1:0] exp;
        logic [2*WIDTH-1:0] got;
        n = 0; bad = 0; seen = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (done) seen = 1;
            else if (!busy || alu_control != 3'b101) bad++;
            start = (n == pulse_at);
            if (n == pulse_at) begin
                multiplicand = 32'd9;
                multiplier   = 32'd9;
            end
        end
        start = 1'b0;
        check({name, "_latency"}, 64'(n), 64'(exp_lat));
        check({name, "_run_busy_addctl"}, 64'(bad), 64'd0);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
        got = {hi, lo};
        check({name, "_product"}, got, exp);
        check({name, "_busy_in_done"}, 64'(busy), 64'd0);
        check({name, "_alu_idle_ops"}, {alu_a, alu_b}, 64'd0);
        @(negedge clk);
        check({name, "_done_one_cycle"}, 64'(done), 64'd0);
        check({name, "_hold"}, {hi, lo}, got);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        longint t0;
        logic [WIDTH-1:0] ra, rb;
        logic rs;

        vecs.push_back('{32'd5,        32'd7,        1'b0, 32'h0000_0000, 32'd35});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
        vecs.push_back('{32'd0,        32'h1234_5678, 1'b0, 32'h0000_0000, 32'h0000_0000});
        vecs.push_back('{32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0000_0001, 32'h0000_0000});
        vecs.push_back('{32'hFFFF_FFFF, 32'd2,        1'b0, 32'h0000_0001, 32'hFFFF_FFFE});
        if (HAS_SIGNED) begin
            vecs.push_back('{32'hFFFF_FFFB, 32'd7,        1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFDD});
            vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001});
            vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000});
        end

        // Reset state while reset_n is held low.
        #3;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_alu_ctl", 64'(alu_control), 64'h5);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].sgn, {vecs[i].exp_hi, vecs[i].exp_lo});
            wait_done(WIDTH + int'(vecs[i].sgn), $sformatf("vec%0d", i), -1);
        end

        // Start request during RUN is dropped: result stays 3x4, no second done.
        start_op(32'd3, 32'd4, 1'b0, 64'd12);
        wait_done(WIDTH, "ignore_start", 10);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("no_second_done", 64'(cnt), 64'd0);
        check("ignore_start_held", {hi, lo}, 64'd12);

        // Asynchronous reset mid-RUN clears everything without waiting for a clock edge.
        start_op(32'hFFFF_0000, 32'hFFFF_FFFF, 1'b0, 64'd0);
        repeat (14) @(negedge clk);
        reset_n = 1'b0;
        t0 = $time;
        fork
            wait (busy == 1'b0 && hi == '0 && lo == '0);
            #1;
        join_any
        disable fork;
        check("reset_async_time", 64'($time - t0), 64'd0);
        check("reset_mid_busy", 64'(busy), 64'd0);
        check("reset_mid_done", 64'(done), 64'd0);
        check("reset_mid_hilo", {hi, lo}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        check("reset_no_done", 64'(cnt), 64'd0);
        start_op(32'd2, 32'd3, 1'b0, 64'd6);
        wait_done(WIDTH, "after_reset", -1);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 10; i++) begin
            ra = $urandom();
            rb = $urandom();
            if ($urandom_range(0, 4) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 4) == 0) rb = 32'hFFFF_FFFF;
            rs = HAS_SIGNED ? 1'($urandom_range(0, 1)) : 1'b0;
            start_op(ra, rb, rs, ref_product(ra, rb, rs));
            wait_done(WIDTH + int'(rs), $sformatf("rand%0d", i), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
